// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - round-robin N:1 packet stream mux with registered output
// Optional STREAM_MUX_FORCE_SEL_EN adds force_en/force_sel to override the arbiter in IDLE.
module stream_mux_rr #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_last,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
`ifdef STREAM_MUX_FORCE_SEL_EN
  ,
  input  logic                     force_en,
  input  logic [SEL_W-1:0]         force_sel
`endif
);

  localparam int SEL_EXP = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  if (SEL_W != SEL_EXP || NUM_IN < 1 || NUM_IN > 16) begin : g_param_check
    $error("stream_mux_rr: SEL_W must be max(1,clog2(NUM_IN)) and NUM_IN must be 1..16");
  end

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t            state, state_next;
  logic [SEL_W-1:0]  grant, grant_next;
  logic [SEL_W-1:0]  last_grant, last_grant_next;
  logic              load_ok;
  logic              take;
  logic              rr_found;
  logic [SEL_W-1:0]  rr_pick;
  logic              rr_hold;
  logic              grant_valid;
  logic              grant_last;
  logic [DATA_W-1:0] grant_data;

  // Steer the granted stream's handshake/payload without variable-width indexing.
  always_comb begin
    grant_valid = 1'b0;
    grant_last  = 1'b0;
    grant_data  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_valid = in_valid[i];
        grant_last  = in_last[i];
        grant_data  = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // First requester at distance 1..NUM_IN above last_grant, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (!rr_found && in_valid[i] && ((int'(last_grant) + k) % NUM_IN) == i) begin
          rr_found = 1'b1;
          rr_pick  = SEL_W'(i);
        end
      end
    end
  end

`ifdef STREAM_MUX_FORCE_SEL_EN
  logic forced;
  logic force_hit;

  always_comb begin
    force_hit = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (force_sel == SEL_W'(i) && in_valid[i]) begin
        force_hit = 1'b1;
      end
    end
  end

  // A forced packet leaves the round-robin pointer where it was.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      forced <= 1'b0;
    end else if (state == S_IDLE && state_next == S_LOCKED) begin
      forced <= force_en;
    end
  end

  assign rr_hold = forced;
`else
  assign rr_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= SEL_W'(NUM_IN - 1);
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    in_ready        = '0;
    take            = 1'b0;
    load_ok         = !out_valid || out_ready;
    case (state)
      S_IDLE: begin
`ifdef STREAM_MUX_FORCE_SEL_EN
        if (force_en) begin
          if (force_hit) begin
            grant_next = force_sel;
            state_next = S_LOCKED;
          end
        end else if (rr_found) begin
          grant_next = rr_pick;
          state_next = S_LOCKED;
        end
`else
        if (rr_found) begin
          grant_next = rr_pick;
          state_next = S_LOCKED;
        end
`endif
      end
      S_LOCKED: begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (grant == SEL_W'(i)) begin
            in_ready[i] = load_ok;
          end
        end
        take = grant_valid && load_ok;
        if (take && grant_last) begin
          state_next = S_IDLE;
          if (!rr_hold) begin
            last_grant_next = grant;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_last  <= grant_last;
      out_sel   <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - randomized and directed bench for stream_mux_rr against a behavioural model
module tb_stream_mux_rr;

  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         resetn;
  logic [N-1:0] in_valid, in_last, in_ready;
  logic [N*W-1:0] in_data;
  logic         out_valid, out_last, out_ready;
  logic [W-1:0] out_data;
  logic [S-1:0] out_sel;

  always #5 clk = ~clk;

  stream_mux_rr #(.NUM_IN(N), .DATA_W(W), .SEL_W(S)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_sel(out_sel),
    .out_ready(out_ready)
`ifdef STREAM_MUX_FORCE_SEL_EN
    , .force_en(1'b0), .force_sel(2'd0)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Source packet buffers, accepted-beat scoreboard, output transfer log.
  logic [8:0] sbuf [N][256];
  int         shead [N];
  int         stail [N];
  bit         pause [N];
  logic [8:0] sb [N][256];
  int         sbh [N];
  int         sbt [N];
  bit         rdy;

  logic [7:0] tr_data [64];
  int         tr_sel [64];
  bit         tr_last [64];
  int         tr_cyc [64];
  int         tr_n;
  int         cyc;

  logic [N-1:0] s_in_ready;
  logic         s_ov, s_ol;
  logic [7:0]   s_od;
  logic [S-1:0] s_sel;

  // Model: owner of the output path and the output register contents.
  bit         m_locked;
  int         m_grant, m_ptr, m_os;
  bit         m_ov, m_ol;
  logic [7:0] m_od;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input bit l);
    sbuf[i][stail[i] & 255] = {l, d};
    stail[i]++;
  endtask

  task automatic drive();
    logic [N-1:0]   v, l;
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) begin
      if (!pause[i] && shead[i] != stail[i]) begin
        v[i] = 1'b1;
        {l[i], d[i*W +: W]} = sbuf[i][shead[i] & 255];
      end else begin
        v[i] = 1'b0;
        l[i] = 1'($urandom_range(0, 1));
        d[i*W +: W] = 8'($urandom);
      end
    end
    in_valid  = v;
    in_last   = l;
    in_data   = d;
    out_ready = rdy;
  endtask

  function automatic void model_step();
    bit was_locked, lok;
    if (!resetn) begin
      m_locked = 0; m_grant = 0; m_ptr = N - 1;
      m_ov = 0; m_od = 0; m_ol = 0; m_os = 0;
      return;
    end
    was_locked = m_locked;
    lok = !m_ov || out_ready;
    if (was_locked && in_valid[m_grant] && lok) begin
      m_ov = 1;
      m_od = in_data[m_grant*W +: W];
      m_ol = in_last[m_grant];
      m_os = m_grant;
      if (in_last[m_grant]) begin
        m_ptr = m_grant;
        m_locked = 0;
      end
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (!was_locked && in_valid != 0) begin
      for (int k = 1; k <= N; k++) begin
        if (in_valid[(m_ptr + k) % N]) begin
          m_grant = (m_ptr + k) % N;
          break;
        end
      end
      m_locked = 1;
    end
  endfunction

  task automatic tick();
    logic [N-1:0] e_rdy, fire;
    int sel;
    @(negedge clk);
    s_in_ready = in_ready; s_ov = out_valid; s_ol = out_last; s_od = out_data; s_sel = out_sel;
    for (int i = 0; i < N; i++) e_rdy[i] = m_locked && (m_grant == i) && (!m_ov || out_ready);
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("out_last", 32'(out_last), 32'(m_ol));
    chk("out_sel", 32'(out_sel), 32'(m_os));
    if (resetn && out_valid && out_ready) begin
      if (tr_n < 64) begin
        tr_data[tr_n] = out_data; tr_sel[tr_n] = int'(out_sel);
        tr_last[tr_n] = out_last; tr_cyc[tr_n] = cyc;
        tr_n++;
      end
      sel = int'(out_sel);
      if (sbh[sel] == sbt[sel]) begin
        chk("sb_unexpected_beat", 32'(1), 32'(0));
      end else begin
        chk("sb_beat", 32'({out_last, out_data}), 32'(sb[sel][sbh[sel] & 255]));
        sbh[sel]++;
      end
    end
    for (int i = 0; i < N; i++) begin
      fire[i] = resetn && in_valid[i] && e_rdy[i];
      if (fire[i]) begin
        sb[i][sbt[i] & 255] = {in_last[i], in_data[i*W +: W]};
        sbt[i]++;
      end
    end
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      if (fire[i]) shead[i]++;
      if (!resetn) sbh[i] = sbt[i];
    end
    drive();
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      shead[i] = stail[i];
      pause[i] = 0;
    end
  endtask

  task automatic reset_dut();
    resetn = 0;
    rdy = 1;
    clear_sources();
    drive();
    tick();
    tick();
    resetn = 1;
    drive();
    tr_n = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    cyc = 0; tr_n = 0;
    for (int i = 0; i < N; i++) begin
      shead[i] = 0; stail[i] = 0; sbh[i] = 0; sbt[i] = 0; pause[i] = 0;
    end
    resetn = 0; rdy = 1;
    drive();
    model_step();

    // Reset state and single-beat packet on stream 2.
    reset_dut();
    chk("rst_out_valid", 32'(s_ov), 32'(0));
    chk("rst_in_ready", 32'(s_in_ready), 32'(0));
    chk("rst_out_sel", 32'(s_sel), 32'(0));
    chk("rst_out_data", 32'(s_od), 32'(0));
    push(2, 8'hA5, 1);
    drive();
    tick();
    chk("t1_c0_in_ready", 32'(s_in_ready), 32'(4'b0000));
    tick();
    chk("t1_c1_in_ready", 32'(s_in_ready), 32'(4'b0100));
    tick();
    chk("t1_c2_out_valid", 32'(s_ov), 32'(1));
    chk("t1_c2_out_data", 32'(s_od), 32'(8'hA5));
    chk("t1_c2_out_sel", 32'(s_sel), 32'(2));
    chk("t1_c2_out_last", 32'(s_ol), 32'(1));
    chk("t1_c2_in_ready", 32'(s_in_ready), 32'(0));
    tick();
    chk("t1_c3_out_valid", 32'(s_ov), 32'(0));

    // All streams busy with single-beat packets.
    reset_dut();
    for (int i = 0; i < N; i++) begin
      push(i, 8'(8'h10 * i), 1);
      push(i, 8'(8'h10 * i + 1), 1);
    end
    drive();
    repeat (20) tick();
    chk("t2_count", 32'(tr_n >= 5), 32'(1));
    chk("t2_sel0", 32'(tr_sel[0]), 32'(0));
    chk("t2_sel1", 32'(tr_sel[1]), 32'(1));
    chk("t2_sel2", 32'(tr_sel[2]), 32'(2));
    chk("t2_sel3", 32'(tr_sel[3]), 32'(3));
    chk("t2_sel4", 32'(tr_sel[4]), 32'(0));
    for (int k = 0; k < 4; k++) chk("t2_gap", 32'(tr_cyc[k+1] - tr_cyc[k]), 32'(2));

    // Multi-beat packet holds the grant through an output stall.
    reset_dut();
    push(1, 8'h11, 0); push(1, 8'h22, 0); push(1, 8'h33, 1);
    drive();
    tick();
    push(0, 8'h44, 1);
    drive();
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      tick();
      if (s_ov && s_od == 8'h11) found = 1;
    end
    chk("t3_first_beat_seen", 32'(found), 32'(1));
    rdy = 0;
    drive();
    repeat (3) begin
      tick();
      chk("t3_stall_valid", 32'(s_ov), 32'(1));
      chk("t3_stall_data", 32'(s_od), 32'(8'h22));
      chk("t3_stall_sel", 32'(s_sel), 32'(1));
      chk("t3_stall_last", 32'(s_ol), 32'(0));
      chk("t3_stall_in_ready", 32'(s_in_ready), 32'(0));
    end
    rdy = 1;
    drive();
    repeat (8) tick();
    chk("t3_count", 32'(tr_n), 32'(4));
    chk("t3_d0", 32'(tr_data[0]), 32'(8'h11));
    chk("t3_d1", 32'(tr_data[1]), 32'(8'h22));
    chk("t3_d2", 32'(tr_data[2]), 32'(8'h33));
    chk("t3_d3", 32'(tr_data[3]), 32'(8'h44));
    chk("t3_sel2", 32'(tr_sel[2]), 32'(1));
    chk("t3_sel3", 32'(tr_sel[3]), 32'(0));
    chk("t3_last2", 32'(tr_last[2]), 32'(1));
    chk("t3_contig", 32'(tr_cyc[2] - tr_cyc[1]), 32'(1));

    // Granted stream 3 pauses mid-packet while stream 0 waits.
    reset_dut();
    push(3, 8'hD1, 0); push(3, 8'hD2, 0); push(3, 8'hD3, 1);
    drive();
    tick();
    tick();
    pause[3] = 1;
    push(0, 8'h0F, 1);
    drive();
    repeat (2) begin
      tick();
      chk("t4_hold_in_ready", 32'(s_in_ready), 32'(4'b1000));
    end
    pause[3] = 0;
    drive();
    repeat (10) tick();
    chk("t4_count", 32'(tr_n), 32'(4));
    chk("t4_d0", 32'(tr_data[0]), 32'(8'hD1));
    chk("t4_d2", 32'(tr_data[2]), 32'(8'hD3));
    chk("t4_sel2", 32'(tr_sel[2]), 32'(3));
    chk("t4_d3", 32'(tr_data[3]), 32'(8'h0F));
    chk("t4_sel3", 32'(tr_sel[3]), 32'(0));

    // Reset mid-packet, then simultaneous requests from 0 and 3.
    reset_dut();
    push(1, 8'hA1, 0); push(1, 8'hA2, 0); push(1, 8'hA3, 1);
    drive();
    repeat (3) tick();
    resetn = 0;
    drive();
    tick();
    resetn = 1;
    clear_sources();
    drive();
    tick();
    chk("t5_out_valid", 32'(s_ov), 32'(0));
    chk("t5_out_data", 32'(s_od), 32'(0));
    chk("t5_out_last", 32'(s_ol), 32'(0));
    chk("t5_out_sel", 32'(s_sel), 32'(0));
    chk("t5_in_ready", 32'(s_in_ready), 32'(0));
    tr_n = 0;
    push(0, 8'hB0, 1); push(3, 8'hB3, 1);
    drive();
    repeat (10) tick();
    chk("t5_count", 32'(tr_n), 32'(2));
    chk("t5_sel0", 32'(tr_sel[0]), 32'(0));
    chk("t5_sel1", 32'(tr_sel[1]), 32'(3));
    chk("t5_d1", 32'(tr_data[1]), 32'(8'hB3));

    // Randomized traffic, stalls, pauses and occasional resets.
    reset_dut();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (shead[i] == stail[i] && $urandom_range(0, 2) == 0) begin
          int len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
        end
        pause[i] = ($urandom_range(0, 3) == 0);
      end
      rdy = ($urandom_range(0, 3) != 0);
      resetn = ($urandom_range(0, 699) != 0);
      drive();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-to-1 streaming multiplexer. Successor to the combinational 8-bit 2:1 mux.
- Selects one of NUM_IN valid/ready input streams using round-robin arbitration.
- Holds the grant for a whole packet, until a beat with in_last is transferred.
- Registers the output, so downstream timing is isolated.
- Sits between multiple packet producers and a single shared consumer.

Parameters:
- NUM_IN, default 4: number of input streams; legal range 1..16.
- DATA_W, default 8: payload width per stream, in bits.
- SEL_W, default 2: width of out_sel. Must equal max(1, clog2(NUM_IN)). Checked by an elaboration-time assertion.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  synchronous reset, active low.
- in_valid  input  NUM_IN  per-stream valid.
- in_data  input  NUM_IN*DATA_W  flat bus; stream i occupies bits [i*DATA_W +: DATA_W].
- in_last  input  NUM_IN  per-stream end-of-packet marker; qualified by in_valid.
- in_ready  output  NUM_IN  per-stream ready; one-hot or zero.
- out_valid  output  1  output beat valid.
- out_data  output  DATA_W  output payload.
- out_last  output  1  end-of-packet marker for the output beat.
- out_sel  output  SEL_W  index of the stream that produced the current output beat.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - FSM enters IDLE.
  - out_valid=0, out_data=0, out_last=0, out_sel=0, in_ready=0.
  - Round-robin pointer last_grant=NUM_IN-1, so input 0 wins first.
- A beat transfers on a port when valid and ready are both 1 at a clk edge.
- load_ok = !out_valid || out_ready. The output register loads only when load_ok=1.
- FSM state IDLE:
  - in_ready=0.
  - If any in_valid bit is set, grant <= first requester searching upward from last_grant+1 modulo NUM_IN, then go to LOCKED.
  - Otherwise stay in IDLE.
- FSM state LOCKED:
  - in_ready[grant] = load_ok; all other in_ready bits are 0.
  - On a transfer from stream grant: out_data <= that stream's data, out_last <= in_last[grant], out_sel <= grant, out_valid <= 1.
  - If that beat has in_last=1: last_grant <= grant and the FSM returns to IDLE.
- Output register when nothing is loaded:
  - Output transfer with no new load: out_valid <= 0.
  - out_valid=1 with out_ready=0: out_data, out_last and out_sel stay stable.
- Latency and throughput:
  - Arbitration costs exactly 1 cycle. in_valid rises in cycle 0 (IDLE) → grant registered at edge 1 → first beat accepted at edge 2 (if load_ok) → out_valid=1 after edge 2.
  - Inside a packet, throughput is 1 beat/cycle while out_ready=1.
  - The minimum gap between back-to-back packets is 1 idle cycle on the output.
- Boundary conditions:
  - Granted stream drops in_valid mid-packet: the grant is held, no beat is emitted, and nothing is arbitrated away.
  - Single-beat packet (in_last=1 on the first beat): LOCKED for one transfer, then IDLE.
  - Non-granted streams asserting valid: in_ready stays 0. Their data must be held by the source (AXI-stream rules).
  - Request withdrawn between the IDLE decision and LOCKED: the FSM stays LOCKED and waits for valid. Sources must not withdraw.
  - NUM_IN=1: grant is always 0; out_sel=0.
  - Reset mid-packet: any partial packet is discarded, outputs take reset values, and the pointer is reset.
  - in_last with in_valid=0 is ignored.

Optional Feature:
- Macro STREAM_MUX_FORCE_SEL_EN.
- When defined, two extra inputs are added: force_en (1 bit) and force_sel (SEL_W bits).
  - While force_en=1 in IDLE, the arbiter grants force_sel if in_valid[force_sel]=1; otherwise it stays in IDLE.
  - last_grant is not updated by a forced packet.
  - force_en has no effect in LOCKED. An in-progress packet always completes.
  - force_sel values >= NUM_IN act as "no request" (stay in IDLE).
- When not defined, these ports do not exist and pure round-robin applies.

Test Plan:
- Reset, then only in_valid[2]=1, single beat data 0xA5 last=1, out_ready=1 → in_ready=4'b0100 for one cycle, 2 cycles after valid. out_valid=1, out_data=0xA5, out_sel=2, out_last=1 for 1 cycle.
- All 4 inputs valid with continuous 1-beat packets, out_ready=1 → out_sel sequence 0,1,2,3,0 with one idle output cycle between packets.
- Stream 1 sends a 3-beat packet (0x11,0x22,0x33) while stream 0 requests; stream 1 holds the grant → out_data 0x11,0x22,0x33 contiguous, then stream 0 is served next.
- Stall: out_ready=0 for 3 cycles while out_valid=1 holding 0x22 → out_data/out_sel/out_last stable and in_ready=0. After out_ready=1, the next beat 0x33 follows with no loss or duplication.
- Stream 3 granted, in_valid[3] drops for 2 cycles mid-packet while stream 0 is valid → in_ready[0] stays 0, grant remains 3, and the packet resumes.
- resetn=0 for one edge mid-packet → all outputs 0 next cycle. A subsequent request from streams 0 and 3 together is granted to stream 0 first.
